// File: rtl/imem_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t  : 2-bit FSM encoding (IDLE=0, RUN=1, HALT=2, FAULT=3),
//                    also the value driven on state_o
//   PKG_RESET_PC   : PC loaded on reset, shared with the rest of the core
//   PKG_HALT_WORD  : default instruction encoding that stops fetch
// ----------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PKG_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PKG_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the instruction-memory port, the IF/ID handoff toward decode and the
// branch redirect request.
//   imem_addr / imem_instr      : word address out, combinational read data in
//   if_valid / id_ready         : IF/ID handshake
//   if_instr / if_pc            : fetched word and its address
//   redirect_valid / redirect_pc: taken branch/jump target
//
// Handshake: a word moves from fetch to decode on a rising edge where
// if_valid && id_ready. While if_valid is high and id_ready is low the
// producer holds if_instr/if_pc stable. id_ready may depend on nothing from
// this block and may be asserted at any time; if_valid never depends on
// id_ready combinationally.
//
// master = fetch sequencer, slave = memory/decode/branch side.
// ----------------------------------------------------------------------------
interface imem_fetch_ctrl_if #(
    parameter int DW = 32
) ();

    logic [DW-1:0] imem_addr;
    logic [DW-1:0] imem_instr;
    logic          id_ready;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [DW-1:0] if_pc;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  id_ready,
        output if_valid,
        output if_instr,
        output if_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output id_ready,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_skid_reg.sv
// ----------------------------------------------------------------------------
// fetch_skid_reg
// Single-entry valid/ready holding register for the IF/ID word.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture d_instr/d_pc this edge (sets valid)
//   flush           : drop the held word (wins over load and drain)
//   ready           : consumer accepts the held word this edge
//   d_instr, d_pc   : word and address to capture
//   valid, instr, pc: registered outputs
// A load on the same edge as a drain replaces the word, so one word per
// cycle flows through when the consumer keeps ready high.
// ----------------------------------------------------------------------------
module fetch_skid_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          flush,
    input  logic          ready,
    input  logic [DW-1:0] d_instr,
    input  logic [DW-1:0] d_pc,
    output logic          valid,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer: owns the PC, drives the word-addressed combinational
// instruction memory and hands fetched words to decode over valid/ready.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : leave IDLE/HALT and begin fetching (ignored in RUN/FAULT)
//   bus         : imem port, IF/ID handshake and redirect (master side)
//   state_o     : current FSM state (IDLE=0, RUN=1, HALT=2, FAULT=3)
//   fault       : high while in FAULT
//   fetch_count : number of completed IF/ID transfers, wraps at 2^DW
// ----------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] RESET_PC  = DW'(PKG_RESET_PC),
    parameter logic [DW-1:0] PC_STEP   = DW'(1),
    parameter logic [DW-1:0] MEM_DEPTH = DW'(1024),
    parameter logic [DW-1:0] HALT_WORD = DW'(PKG_HALT_WORD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    imem_fetch_ctrl_if.master     bus,
    output logic [1:0]            state_o,
    output logic                  fault,
    output logic [DW-1:0]         fetch_count
);

    fetch_state_t  state;
    logic [DW-1:0] pc;
    logic          fault_q;

    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [DW-1:0] if_pc;

    logic          slot_free;
    logic          run_go;
    logic          advance;
    logic          fault_hit;
    logic          flush;
    logic          xfer_counted;

    // The IF/ID slot can take a new word when empty or being drained now.
    assign slot_free = !if_valid || bus.id_ready;
    assign run_go    = (state == ST_RUN) && !bus.redirect_valid && slot_free;
    assign advance   = run_go && (pc < MEM_DEPTH);
    // Out-of-range PC is only flagged when a fetch would actually happen, so a
    // stalled word ahead of it still gets delivered first.
    assign fault_hit = run_go && (pc >= MEM_DEPTH);

    // Redirect discards the pending word in RUN/HALT; in IDLE the slot is
    // empty and in FAULT redirect is ignored entirely.
    assign flush        = bus.redirect_valid && ((state == ST_RUN) || (state == ST_HALT));
    assign xfer_counted = if_valid && bus.id_ready && !flush;

    fetch_skid_reg #(.DW(DW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (advance),
        .flush   (flush),
        .ready   (bus.id_ready),
        .d_instr (bus.imem_instr),
        .d_pc    (pc),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );

    assign bus.imem_addr = pc;
    assign bus.if_valid  = if_valid;
    assign bus.if_instr  = if_instr;
    assign bus.if_pc     = if_pc;
    assign state_o       = state;
    assign fault         = fault_q;

    // PC and control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (bus.redirect_valid) pc <= bus.redirect_pc;
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.redirect_valid) begin
                        pc <= bus.redirect_pc;
                    end else if (advance) begin
                        pc <= pc + PC_STEP;
                        // The halt word is still captured and delivered.
                        if (bus.imem_instr == HALT_WORD) state <= ST_HALT;
                    end else if (fault_hit) begin
                        state   <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Sticky until reset.
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (xfer_counted) begin
            fetch_count <= fetch_count + DW'(1);
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    localparam int          DW    = 32;
    localparam int          DEPTH = 128;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  state_o;
    logic        fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.DW(DW)) bus ();

    imem_fetch_ctrl #(
        .DW        (DW),
        .RESET_PC  (32'd0),
        .PC_STEP   (32'd1),
        .MEM_DEPTH (32'd128),
        .HALT_WORD (HALT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .state_o     (state_o),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    logic [31:0] mem [0:255];
    assign bus.imem_instr = (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:0]]
                                                      : {16'hBAD0, bus.imem_addr[15:0]};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc);
        start              = st;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    // Assert reset mid-cycle (away from edges), release on the next negedge.
    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
    endtask

    // ---------------- reference model + scoreboard ----------------
    // exp_q holds the {pc, instr} words fetched but not yet taken by decode.
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [63:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < 32'd256) ? mem[a[7:0]] : {16'hBAD0, a[15:0]};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'd0;
        m_count = 32'd0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] w;
        logic        have;
        w    = mem_word(m_pc);
        have = (exp_q.size() != 0);
        if (m_state == 3) begin
            if (have && rdy) begin
                void'(exp_q.pop_front());
                m_count++;
            end
        end else if (rv) begin
            m_pc = rpc;
            exp_q.delete();
            if (m_state != 1 && st) m_state = 1;
        end else begin
            if (m_state == 1 && (!have || rdy)) begin
                if (have) begin
                    void'(exp_q.pop_front());
                    m_count++;
                end
                if (m_pc < DEPTH) begin
                    exp_q.push_back({m_pc, w});
                    m_pc = m_pc + 32'd1;
                    if (w == HALT) m_state = 2;
                end else begin
                    m_state = 3;
                end
            end else if (m_state != 1) begin
                if (have && rdy) begin
                    void'(exp_q.pop_front());
                    m_count++;
                end
                if (st) m_state = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, {30'b0, state_o}, m_state);
        check({tag, "_fault"}, {31'b0, fault}, {31'b0, (m_state == 3)});
        check({tag, "_addr"}, bus.imem_addr, m_pc);
        check({tag, "_count"}, fetch_count, m_count);
        check({tag, "_valid"}, {31'b0, bus.if_valid}, {31'b0, (exp_q.size() != 0)});
        if (exp_q.size() != 0) begin
            check({tag, "_if_pc"}, bus.if_pc, exp_q[0][63:32]);
            check({tag, "_if_instr"}, bus.if_instr, exp_q[0][31:0]);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic [1:0]  e_state;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic [1:0] es, input logic ev, input logic [31:0] eip,
                                input logic [31:0] ein, input logic [31:0] ea, input logic [31:0] ec);
        vec_t v;
        v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_state = es; v.e_valid = ev; v.e_ifpc = eip; v.e_instr = ein;
        v.e_addr = ea; v.e_count = ec;
        return v;
    endfunction

    initial begin
        int fault_cycles;

        for (int a = 0; a < 256; a++) mem[a] = 32'h10 + a;
        mem[3]    = HALT;
        mem[8'h43] = HALT;
        drive(1'b0, 1'b0, 1'b0, 32'd0);

        //              st rdy rv rpc      state vld ifpc   instr  addr   cnt
        vecs[0]  = mk(1, 1, 0, 0,        1, 0, 0,     0,     0,     0);
        vecs[1]  = mk(0, 1, 0, 0,        1, 1, 0,     32'h10, 1,    0);
        vecs[2]  = mk(0, 1, 0, 0,        1, 1, 1,     32'h11, 2,    1);
        vecs[3]  = mk(0, 0, 0, 0,        1, 1, 1,     32'h11, 2,    1);
        vecs[4]  = mk(0, 0, 0, 0,        1, 1, 1,     32'h11, 2,    1);
        vecs[5]  = mk(0, 0, 0, 0,        1, 1, 1,     32'h11, 2,    1);
        vecs[6]  = mk(0, 1, 0, 0,        1, 1, 2,     32'h12, 3,    2);
        vecs[7]  = mk(0, 1, 0, 0,        2, 1, 3,     HALT,  4,     3);
        vecs[8]  = mk(0, 0, 0, 0,        2, 1, 3,     HALT,  4,     3);
        vecs[9]  = mk(0, 1, 0, 0,        2, 0, 0,     0,     4,     4);
        vecs[10] = mk(0, 1, 0, 0,        2, 0, 0,     0,     4,     4);
        vecs[11] = mk(1, 1, 0, 0,        1, 0, 0,     0,     4,     4);
        vecs[12] = mk(0, 1, 0, 0,        1, 1, 4,     32'h14, 5,    4);
        vecs[13] = mk(0, 0, 0, 0,        1, 1, 4,     32'h14, 5,    4);
        vecs[14] = mk(0, 0, 1, 32'h40,   1, 0, 0,     0,     32'h40, 4);
        vecs[15] = mk(0, 1, 0, 0,        1, 1, 32'h40, 32'h50, 32'h41, 4);
        vecs[16] = mk(0, 1, 0, 0,        1, 1, 32'h41, 32'h51, 32'h42, 5);
        vecs[17] = mk(0, 1, 1, 32'h43,   1, 0, 0,     0,     32'h43, 5);
        vecs[18] = mk(0, 1, 1, 32'h10,   1, 0, 0,     0,     32'h10, 5);
        vecs[19] = mk(0, 1, 0, 0,        1, 1, 32'h10, 32'h20, 32'h11, 5);
        vecs[20] = mk(0, 1, 1, 32'h7E,   1, 0, 0,     0,     32'h7E, 5);
        vecs[21] = mk(0, 1, 0, 0,        1, 1, 32'h7E, 32'h8E, 32'h7F, 5);
        vecs[22] = mk(0, 0, 0, 0,        1, 1, 32'h7E, 32'h8E, 32'h7F, 5);
        vecs[23] = mk(0, 1, 0, 0,        1, 1, 32'h7F, 32'h8F, 32'h80, 6);
        vecs[24] = mk(0, 0, 0, 0,        1, 1, 32'h7F, 32'h8F, 32'h80, 6);
        vecs[25] = mk(0, 1, 0, 0,        3, 0, 0,     0,     32'h80, 7);
        vecs[26] = mk(1, 1, 1, 32'h00,   3, 0, 0,     0,     32'h80, 7);
        vecs[27] = mk(0, 1, 0, 0,        3, 0, 0,     0,     32'h80, 7);

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", {30'b0, state_o}, 32'd0);
        check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_instr", bus.if_instr, 32'd0);

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].st, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_state", i), {30'b0, state_o}, {30'b0, vecs[i].e_state});
            check($sformatf("vec%0d_fault", i), {31'b0, fault}, {31'b0, (vecs[i].e_state == 2'd3)});
            check($sformatf("vec%0d_valid", i), {31'b0, bus.if_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_count", i), fetch_count, vecs[i].e_count);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_if_pc", i), bus.if_pc, vecs[i].e_ifpc);
                check($sformatf("vec%0d_if_instr", i), bus.if_instr, vecs[i].e_instr);
            end
        end

        // Leaving FAULT only through reset, asserted between edges.
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        async_reset_pulse();
        check("fault_rst_state", {30'b0, state_o}, 32'd0);
        check("fault_rst_fault", {31'b0, fault}, 32'd0);
        check("fault_rst_addr", bus.imem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Mid-stream asynchronous reset.
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_count", fetch_count, 32'd3);
        check("stream_state", {30'b0, state_o}, 32'd2);
        check("stream_if_pc", bus.if_pc, 32'd3);
        async_reset_pulse();
        check("async_valid", {31'b0, bus.if_valid}, 32'd0);
        check("async_count", fetch_count, 32'd0);
        check("async_if_pc", bus.if_pc, 32'd0);
        check("async_if_instr", bus.if_instr, 32'd0);
        check("async_addr", bus.imem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the reference model.
        for (int a = 0; a < 256; a++) mem[a] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        model_reset();
        check_model("rand_init");
        fault_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            logic        st, rdy, rv;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom_range(0, 135);
            drive(st, rdy, rv, rpc);
            model_step(st, rdy, rv, rpc);
            @(posedge clk);
            @(negedge clk);
            check_model($sformatf("rand%0d", i));
            if (m_state == 3) fault_cycles++;
            if (i == 300 || fault_cycles > 3) begin
                drive(1'b0, 1'b0, 1'b0, 32'd0);
                async_reset_pulse();
                model_reset();
                check_model($sformatf("rand%0d_rst", i));
                @(negedge clk);
                rst = 1'b0;
                fault_cycles = 0;
            end
        end

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
